// File: rtl/scbuf_fbwr_seq.sv
// ---------------------------------------------------------------------------
// scbuf_fbwr_seq
//
// Write sequencer for the L2 fill buffer. It turns DRAM fill beats (four per
// entry) and OFF-mode store writes into registered word write enables, a
// write wordline and a store-data select. It also tracks which fill buffer
// entries hold a complete line.
//
// Fill beats always take priority over stores. A store is acknowledged
// combinationally in any cycle that has no fill beat.
//
// Optional build macro:
//   SCBUF_FBWR_ERRCHK_EN  adds the fill_err output. A mid-fill beat whose id
//                         differs from the latched entry sets this sticky
//                         flag, and that beat is dropped.
//
// Ports:
//   rclk                          clock; all state updates on its rising edge
//   reset                         synchronous, active-high reset
//   dram_fill_vld_r1              one DRAM fill beat present this cycle
//   dram_fill_id_r1   [2:0]       fill buffer entry for this beat
//   st_req_c2                     store write request, held until acked
//   st_id_c2          [2:0]       fill buffer entry for the store
//   st_wmask_c2       [15:0]      word mask for the store
//   st_ack_c2                     store accepted this cycle (combinational)
//   sctag_scbuf_fbwr_wen_r2 [15:0] word write enables (registered)
//   sctag_scbuf_fbwr_wl_r2  [2:0]  write wordline / entry (registered)
//   sctag_scbuf_fbd_stdatasel_c3   select store data for this write
//   fill_done                     one-cycle pulse, last beat of an entry written
//   fill_done_id      [2:0]       entry that completed
//   fb_filled         [7:0]       per-entry line-complete status
//   fb_clr            [7:0]       clears fb_filled bits (entry dealloc)
//   fill_err                      sticky id-mismatch flag (macro builds only)
// ---------------------------------------------------------------------------
module scbuf_fbwr_seq (
  input  logic        rclk,
  input  logic        reset,
  input  logic        dram_fill_vld_r1,
  input  logic [2:0]  dram_fill_id_r1,
  input  logic        st_req_c2,
  input  logic [2:0]  st_id_c2,
  input  logic [15:0] st_wmask_c2,
  output logic        st_ack_c2,
  output logic [15:0] sctag_scbuf_fbwr_wen_r2,
  output logic [2:0]  sctag_scbuf_fbwr_wl_r2,
  output logic        sctag_scbuf_fbd_stdatasel_c3,
  output logic        fill_done,
  output logic [2:0]  fill_done_id,
  output logic [7:0]  fb_filled,
`ifdef SCBUF_FBWR_ERRCHK_EN
  output logic        fill_err,
`endif
  input  logic [7:0]  fb_clr
);

  localparam int unsigned ID_W   = 3;
  localparam int unsigned WEN_W  = 16;
  localparam int unsigned NENT   = 8;
  localparam int unsigned BCNT_W = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [ID_W-1:0]     id_q, id_d;

  logic [WEN_W-1:0]    wen_d;
  logic [ID_W-1:0]     wl_d;
  logic                sel_d;
  logic                done_d;
  logic [ID_W-1:0]     done_id_d;
  logic [NENT-1:0]     fb_set;
  logic [NENT-1:0]     fb_d;
  logic                beat_wr;
  logic [ID_W-1:0]     beat_id;

`ifdef SCBUF_FBWR_ERRCHK_EN
  logic                id_mismatch;
  logic                err_d;
`endif

  // Store acceptance: fill beats win, nothing is accepted during reset.
  assign st_ack_c2 = st_req_c2 & ~dram_fill_vld_r1 & ~reset;

  // A beat in IDLE opens a new entry; in FILL it belongs to the latched one.
  assign beat_id = (state_q == IDLE) ? dram_fill_id_r1 : id_q;

`ifdef SCBUF_FBWR_ERRCHK_EN
  assign id_mismatch = (state_q == FILL) && (dram_fill_id_r1 != id_q);
  // Mismatched beats are dropped, not written.
  assign beat_wr     = dram_fill_vld_r1 & ~id_mismatch;
`else
  // Without checking, a stray id mid-fill is written to the latched entry.
  assign beat_wr     = dram_fill_vld_r1;
`endif

  // Completed-line status updates one cycle after the fill_done pulse.
  assign fb_set = fill_done ? (NENT'(1) << fill_done_id) : '0;

  // State register and all registered outputs.
  always_ff @(posedge rclk) begin
    if (reset) begin
      state_q                      <= IDLE;
      bcnt_q                       <= '0;
      id_q                         <= '0;
      sctag_scbuf_fbwr_wen_r2      <= '0;
      sctag_scbuf_fbwr_wl_r2       <= '0;
      sctag_scbuf_fbd_stdatasel_c3 <= 1'b0;
      fill_done                    <= 1'b0;
      fill_done_id                 <= '0;
      fb_filled                    <= '0;
`ifdef SCBUF_FBWR_ERRCHK_EN
      fill_err                     <= 1'b0;
`endif
    end else begin
      state_q                      <= state_d;
      bcnt_q                       <= bcnt_d;
      id_q                         <= id_d;
      sctag_scbuf_fbwr_wen_r2      <= wen_d;
      sctag_scbuf_fbwr_wl_r2       <= wl_d;
      sctag_scbuf_fbd_stdatasel_c3 <= sel_d;
      fill_done                    <= done_d;
      fill_done_id                 <= done_id_d;
      fb_filled                    <= fb_d;
`ifdef SCBUF_FBWR_ERRCHK_EN
      fill_err                     <= err_d;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    id_d      = id_q;
    wen_d     = '0;
    wl_d      = sctag_scbuf_fbwr_wl_r2;
    sel_d     = 1'b0;
    done_d    = 1'b0;
    done_id_d = fill_done_id;

    case (state_q)
      IDLE: begin
        if (beat_wr) begin
          state_d = FILL;
          id_d    = dram_fill_id_r1;
          bcnt_d  = BCNT_W'(1);
        end
      end
      FILL: begin
        if (beat_wr) begin
          // bcnt wraps from 3 to 0 as the entry completes.
          bcnt_d = BCNT_W'(bcnt_q + BCNT_W'(1));
          if (bcnt_q == BCNT_W'(3)) begin
            state_d   = IDLE;
            done_d    = 1'b1;
            done_id_d = id_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
        bcnt_d  = '0;
      end
    endcase

    // Beat k enables words 4k+3..4k; otherwise an accepted store drives its mask.
    if (beat_wr) begin
      wen_d = WEN_W'(4'hF) << {bcnt_q, 2'b00};
      wl_d  = beat_id;
    end else if (st_ack_c2) begin
      wen_d = st_wmask_c2;
      wl_d  = st_id_c2;
      sel_d = 1'b1;
    end

    // Dealloc clear wins over a same-cycle set.
    fb_d = (fb_filled | fb_set) & ~fb_clr;

`ifdef SCBUF_FBWR_ERRCHK_EN
    err_d = fill_err | (dram_fill_vld_r1 & id_mismatch);
`endif
  end

endmodule

// File: tb/tb_scbuf_fbwr_seq.sv
// ---------------------------------------------------------------------------
// tb_scbuf_fbwr_seq
//
// Self-checking bench for scbuf_fbwr_seq. Each cycle, the stimulus task drives
// the inputs on the falling edge. A behavioural model then pushes the expected
// registered outputs onto a queue. After the next rising edge, the entry is
// popped and compared with what the DUT shows.
// ---------------------------------------------------------------------------
module tb_scbuf_fbwr_seq;

  logic        rclk;
  logic        reset;
  logic        dram_fill_vld_r1;
  logic [2:0]  dram_fill_id_r1;
  logic        st_req_c2;
  logic [2:0]  st_id_c2;
  logic [15:0] st_wmask_c2;
  logic        st_ack_c2;
  logic [15:0] sctag_scbuf_fbwr_wen_r2;
  logic [2:0]  sctag_scbuf_fbwr_wl_r2;
  logic        sctag_scbuf_fbd_stdatasel_c3;
  logic        fill_done;
  logic [2:0]  fill_done_id;
  logic [7:0]  fb_filled;
  logic [7:0]  fb_clr;
`ifdef SCBUF_FBWR_ERRCHK_EN
  logic        fill_err;
`endif

  scbuf_fbwr_seq dut (
    .rclk                         (rclk),
    .reset                        (reset),
    .dram_fill_vld_r1             (dram_fill_vld_r1),
    .dram_fill_id_r1              (dram_fill_id_r1),
    .st_req_c2                    (st_req_c2),
    .st_id_c2                     (st_id_c2),
    .st_wmask_c2                  (st_wmask_c2),
    .st_ack_c2                    (st_ack_c2),
    .sctag_scbuf_fbwr_wen_r2      (sctag_scbuf_fbwr_wen_r2),
    .sctag_scbuf_fbwr_wl_r2       (sctag_scbuf_fbwr_wl_r2),
    .sctag_scbuf_fbd_stdatasel_c3 (sctag_scbuf_fbd_stdatasel_c3),
    .fill_done                    (fill_done),
    .fill_done_id                 (fill_done_id),
    .fb_filled                    (fb_filled),
`ifdef SCBUF_FBWR_ERRCHK_EN
    .fill_err                     (fill_err),
`endif
    .fb_clr                       (fb_clr)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  typedef struct {
    logic [15:0] wen;
    logic [2:0]  wl;
    logic        sel;
    logic        done;
    logic        chk_id;
    logic [2:0]  done_id;
    logic [7:0]  fb;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic       m_fill;
  logic [1:0] m_bcnt;
  logic [2:0] m_id;
  logic [2:0] m_wl;
  logic       m_done;
  logic [2:0] m_done_id;
  logic [7:0] m_fb;
  logic       m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, predict, then compare the registered result.
  task automatic cycle(input logic rst, input logic vld, input logic [2:0] fid,
                       input logic req, input logic [2:0] sid, input logic [15:0] mask,
                       input logic [7:0] clr);
    exp_t e;
    exp_t o;
    logic done_now;
    logic bad;
    @(negedge rclk);
    reset            = rst;
    dram_fill_vld_r1 = vld;
    dram_fill_id_r1  = fid;
    st_req_c2        = req;
    st_id_c2         = sid;
    st_wmask_c2      = mask;
    fb_clr           = clr;
    #1;
    check("st_ack", 32'(st_ack_c2), 32'(req && !vld && !rst));

    e.wen = '0; e.wl = m_wl; e.sel = 1'b0; e.done = 1'b0; e.chk_id = 1'b0;
    e.done_id = m_done_id; e.fb = m_fb; e.err = m_err;
    if (rst) begin
      m_fill = 0; m_bcnt = 0; m_id = 0; m_wl = 0;
      m_done = 0; m_done_id = 0; m_fb = 0; m_err = 0;
      e.wl = 0; e.done_id = 0; e.chk_id = 1'b1; e.fb = 0; e.err = 0;
    end else begin
      e.fb = (m_fb | (m_done ? (8'(1) << m_done_id) : 8'h00)) & ~clr;
      done_now = 1'b0;
      bad = m_fill && (fid != m_id);
`ifndef SCBUF_FBWR_ERRCHK_EN
      bad = 1'b0;
`endif
      if (vld && bad) begin
        e.err = 1'b1;
      end else if (vld) begin
        if (!m_fill) begin
          m_fill = 1'b1;
          m_id   = fid;
        end
        e.wen = 16'h000F << (4 * m_bcnt);
        e.wl  = m_id;
        if (m_bcnt == 2'd3) begin
          done_now = 1'b1;
          m_fill   = 1'b0;
        end
        m_bcnt = m_bcnt + 2'd1;
      end else if (req) begin
        e.wen = mask;
        e.wl  = sid;
        e.sel = 1'b1;
      end
      e.done = done_now;
      if (done_now) begin
        e.done_id = m_id;
        e.chk_id  = 1'b1;
      end
      m_done    = done_now;
      m_done_id = e.done_id;
      m_fb      = e.fb;
      m_wl      = e.wl;
      m_err     = e.err;
    end
    exp_q.push_back(e);

    @(posedge rclk);
    #1;
    o = exp_q.pop_front();
    check("wen", 32'(sctag_scbuf_fbwr_wen_r2), 32'(o.wen));
    check("wl", 32'(sctag_scbuf_fbwr_wl_r2), 32'(o.wl));
    check("stdatasel", 32'(sctag_scbuf_fbd_stdatasel_c3), 32'(o.sel));
    check("fill_done", 32'(fill_done), 32'(o.done));
    if (o.chk_id) check("fill_done_id", 32'(fill_done_id), 32'(o.done_id));
    check("fb_filled", 32'(fb_filled), 32'(o.fb));
`ifdef SCBUF_FBWR_ERRCHK_EN
    check("fill_err", 32'(fill_err), 32'(o.err));
`endif
  endtask

  task automatic beat(input logic [2:0] fid);
    cycle(1'b0, 1'b1, fid, 1'b0, 3'd0, 16'h0, 8'h00);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 8'h00);
  endtask

  initial begin
    reset = 1'b1; dram_fill_vld_r1 = 0; dram_fill_id_r1 = 0;
    st_req_c2 = 0; st_id_c2 = 0; st_wmask_c2 = 0; fb_clr = 0;
    m_fill = 0; m_bcnt = 0; m_id = 0; m_wl = 0;
    m_done = 0; m_done_id = 0; m_fb = 0; m_err = 0;

    // Reset state
    cycle(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 8'h00);
    cycle(1'b1, 1'b0, 3'd0, 1'b1, 3'd4, 16'hFFFF, 8'h00);
    idle(1);

    // Back-to-back fill of entry 5
    for (int k = 0; k < 4; k++) beat(3'd5);
    idle(2);

    // Store colliding with a fill beat, then acked on the next free cycle
    cycle(1'b0, 1'b1, 3'd1, 1'b1, 3'd2, 16'h0101, 8'h00);
    cycle(1'b0, 1'b0, 3'd0, 1'b1, 3'd2, 16'h0101, 8'h00);
    idle(1);
    // Store to the entry being filled, then finish it
    cycle(1'b0, 1'b0, 3'd0, 1'b1, 3'd1, 16'h8421, 8'h00);
    for (int k = 0; k < 3; k++) beat(3'd1);
    idle(2);
    cycle(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 8'h22);

    // Gapped fill of entry 6
    for (int k = 0; k < 4; k++) begin
      beat(3'd6);
      idle(2);
    end

    // Reset mid-fill, then a fresh fill of the same entry
    beat(3'd3);
    beat(3'd3);
    cycle(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 8'h00);
    idle(1);
    for (int k = 0; k < 4; k++) beat(3'd3);
    idle(2);

    // Dealloc clear coincident with fill_done on entry 5
    for (int k = 0; k < 4; k++) beat(3'd5);
    cycle(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 8'h20);
    idle(2);

    // Wrong id mid-fill
    beat(3'd4);
    beat(3'd7);
`ifdef SCBUF_FBWR_ERRCHK_EN
    for (int k = 0; k < 3; k++) beat(3'd4);
`else
    for (int k = 0; k < 2; k++) beat(3'd4);
`endif
    idle(2);

    // Randomised mix of fills, stores and clears
    for (int i = 0; i < 60; i++) begin
      logic       v;
      logic [2:0] f;
      v = 1'($urandom_range(0, 1));
      f = m_fill ? m_id : 3'($urandom_range(0, 7));
      cycle(1'b0, v, f, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            16'($urandom), (($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00));
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scbuf_fbwr_seq.md
SCBUF_FBWR_SEQ -- requirements
Module: scbuf_fbwr_seq

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, as follows:
- rclk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
REQ-002 SHALL have these data and control ports:
- dram_fill_vld_r1  in  1  one DRAM fill beat is present this cycle.
- dram_fill_id_r1  in  3  fill buffer entry for this beat.
- st_req_c2  in  1  OFF-mode store write request; held until acked.
- st_id_c2  in  3  fill buffer entry for the store.
- st_wmask_c2  in  16  word mask for the store.
- st_ack_c2  out  1  store accepted this cycle.
- sctag_scbuf_fbwr_wen_r2  out  16  word write enables.
- sctag_scbuf_fbwr_wl_r2  out  3  write wordline (entry).
- sctag_scbuf_fbd_stdatasel_c3  out  1  select store data for this write.
- fill_done  out  1  single-cycle pulse: fourth beat of an entry written.
- fill_done_id  out  3  entry that completed.
- fb_filled  out  8  per-entry "line complete" status.
- fb_clr  in  8  clears fb_filled bits (entry dealloc).
- fill_err  out  1  sticky protocol error; present only when the macro in REQ-019 is defined.

Function
REQ-003 SHALL register all outputs except st_ack_c2, which is combinational; write outputs are valid one cycle after the accepted r1/c2 input.
REQ-004 SHALL use states IDLE and FILL plus a 2-bit beat counter bcnt.
REQ-005 IDLE + dram_fill_vld_r1 -> FILL; latch id; write beat 0; bcnt=1.
REQ-006 Each valid beat in FILL SHALL write beat bcnt, then increment bcnt.
REQ-007 The beat with bcnt=3 SHALL return the FSM to IDLE, wrap bcnt to 0, and next cycle pulse fill_done with fill_done_id=id and set fb_filled[id].
REQ-008 Beat k SHALL drive wen[4k+3:4k]=4'hF, all other wen bits 0, wl=id, stdatasel=0.
REQ-009 Non-valid cycles in FILL SHALL hold state; beats need not be back-to-back.
REQ-010 A store SHALL be accepted (st_ack_c2=1) only when dram_fill_vld_r1=0 in that cycle; fill beats always win.
REQ-011 An accepted store SHALL drive, next cycle, wen=st_wmask_c2, wl=st_id_c2, stdatasel=1; it SHALL NOT change FSM, bcnt or fb_filled.
REQ-012 Stores SHALL be accepted in IDLE or FILL, including to an entry mid-fill.
REQ-013 Cycles with no write SHALL drive wen=0 and stdatasel=0; wl holds its last value.
REQ-014 fb_clr[i] SHALL clear fb_filled[i] next cycle; fb_clr has priority over a same-cycle set of the same bit.
REQ-015 In FILL, a beat with dram_fill_id_r1 != latched id SHALL still be written using the latched id (macro off) or flagged per REQ-019 (macro on).

Reset
REQ-016 Reset SHALL force: state=IDLE, bcnt=0, wen=0, wl=0, stdatasel=0, fill_done=0, fill_done_id=0, fb_filled=0, fill_err=0.
REQ-017 Reset mid-fill SHALL abandon the fill: no fill_done and no fb_filled set; the next beat starts at beat 0.
REQ-018 st_ack_c2 SHALL be 0 while reset is high.

Configuration
REQ-019 With SCBUF_FBWR_ERRCHK_EN defined:
- fill_err port exists.
- fill_err sets (sticky until reset) on a REQ-015 id mismatch; that beat is dropped (wen=0, bcnt unchanged).
Without the macro: no fill_err port, no checking logic, and behaviour is per REQ-015.

Verification
REQ-020 Back-to-back fill: beats at t0..t3, id=5.
- wen=000F,00F0,0F00,F000 and wl=5 at t1..t4.
- fill_done=1 with fill_done_id=5 at t4; fb_filled=8'h20 at t5.
REQ-021 Store collision: st_req_c2=1, id=2, mask=16'h0101, arriving with a fill beat.
- No ack that cycle; ack in the next idle cycle.
- Following cycle: wen=0101, wl=2, stdatasel=1.
REQ-022 Gapped fill: beats with 2 idle cycles between them.
- Enables are identical to REQ-020; fill_done only after the 4th beat.
REQ-023 Reset after 2 beats of id=3, then a new 4-beat fill of id=3.
- First post-reset write is wen=000F; exactly one fill_done.
REQ-024 fb_clr[5] and fill_done on entry 5 in the same cycle: fb_filled[5] ends at 0.
REQ-025 Macro on: mid-fill beat with a wrong id.
- fill_err=1 next cycle; that beat's wen=0; the fill completes after 4 good beats.
